select: RTL and testbench

//  Carry-select adder: sum = X + Y + Cin, with carry out.
//  - Upper blocks precompute results for carry-in 0 and carry-in 1.
//  - The real block carry then picks one of the two results.
//  - Outputs are registered once, so the block can sit in a clocked datapath.
//  - Default width is 4 bits, split into 2-bit blocks.

---
 rtl/select_pkg.sv | 22 ++
 rtl/csa_rca_block.sv | 31 +++
 rtl/select.sv | 89 ++++++++
 tb/tb_select.sv | 139 +++++++++++++
 4 files changed

// File: rtl/select_pkg.sv
`default_nettype none
// ============================================================================
// Module  : select_pkg
// Brief   : Shared constants and reference arithmetic for the carry-select adder
// Revision: 1.0 - initial release
// ============================================================================
package select_pkg;

  localparam int CSA_WIDTH = 4;
  localparam int CSA_BLK   = 2;

  typedef logic [CSA_WIDTH:0] csa_result_t;

  // Full-precision reference {Cout,sum} for the default configuration
  function automatic csa_result_t csa_ref(input logic [CSA_WIDTH-1:0] x,
                                          input logic [CSA_WIDTH-1:0] y,
                                          input logic                 ci);
    return {1'b0, x} + {1'b0, y} + {{CSA_WIDTH{1'b0}}, ci};
  endfunction

endpackage
`default_nettype wire

// File: rtl/csa_rca_block.sv
`default_nettype none
// ============================================================================
// Module  : csa_rca_block
// Brief   : BLK-bit ripple-carry adder built from full-adder equations
// Revision: 1.0 - initial release
// ============================================================================
module csa_rca_block
  import select_pkg::*;
#(
  parameter int BLK = CSA_BLK
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           ci,
  output logic [BLK-1:0] s,
  output logic           co
);

  logic [BLK:0] w_c;

  assign w_c[0] = ci;

  for (genvar i = 0; i < BLK; i++) begin : g_fa
    assign s[i]     = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign co = w_c[BLK];

endmodule
`default_nettype wire

// File: rtl/select.sv
`default_nettype none
// ============================================================================
// Module  : select
// Brief   : Carry-select adder, {Cout,sum} = X + Y + Cin, registered output
// Revision: 1.0 - initial release
// ============================================================================
module select
  import select_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH,
  parameter int BLK   = CSA_BLK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Cin,
  output logic [WIDTH-1:0] sum,
  output logic             Cout
);

  localparam int NBLK = WIDTH / BLK;

  // Per-block candidate results for block carry-in 0 (s0/co0) and 1 (s1/co1)
  logic [BLK-1:0] w_s0  [NBLK];
  logic [BLK-1:0] w_s1  [NBLK];
  logic           w_co0 [NBLK];
  logic           w_co1 [NBLK];

  logic [WIDTH-1:0] w_sum;
  logic             w_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    if (k == 0) begin : g_rca0
      csa_rca_block #(.BLK(BLK)) u_rca (
        .a  (X[BLK-1:0]),
        .b  (Y[BLK-1:0]),
        .ci (Cin),
        .s  (w_s0[0]),
        .co (w_co0[0])
      );
      // Block 0 already uses the true carry, so both candidates are identical
      assign w_s1[0]  = w_s0[0];
      assign w_co1[0] = w_co0[0];
    end else begin : g_csel
      csa_rca_block #(.BLK(BLK)) u_rca_c0 (
        .a  (X[k*BLK +: BLK]),
        .b  (Y[k*BLK +: BLK]),
        .ci (1'b0),
        .s  (w_s0[k]),
        .co (w_co0[k])
      );
      csa_rca_block #(.BLK(BLK)) u_rca_c1 (
        .a  (X[k*BLK +: BLK]),
        .b  (Y[k*BLK +: BLK]),
        .ci (1'b1),
        .s  (w_s1[k]),
        .co (w_co1[k])
      );
    end
  end

  // Select chain: each block's real carry-in is the previous block's chosen carry
  always_comb begin
    w_sum   = '0;
    w_carry = 1'b0;
    for (int k = 0; k < NBLK; k++) begin
      w_sum[k*BLK +: BLK] = w_carry ? w_s1[k] : w_s0[k];
      w_carry             = w_carry ? w_co1[k] : w_co0[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else begin
      r_sum  <= w_sum;
      r_cout <= w_carry;
    end
  end

  assign sum  = r_sum;
  assign Cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_select.sv
`default_nettype none
// ============================================================================
// Module  : tb_select
// Brief   : Self-checking bench for the registered carry-select adder
// Revision: 1.0 - initial release
// ============================================================================
module tb_select;
  import select_pkg::*;

  localparam int W = CSA_WIDTH;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] X;
  logic [W-1:0] Y;
  logic [3:0]   cin_bus;
  logic [W-1:0] sum;
  logic         Cout;

  int vectors     = 0;
  int miscompares = 0;

  logic [W:0] prev_exp;
  logic [8:0] v;

  always #5 clk = ~clk;

  select #(.WIDTH(W), .BLK(CSA_BLK)) dut (
    .clk  (clk),
    .rst  (rst),
    .X    (X),
    .Y    (Y),
    .Cin  (cin_bus[0]),
    .sum  (sum),
    .Cout (Cout)
  );

  function automatic logic [W:0] model(input logic [W-1:0] a,
                                       input logic [W-1:0] b,
                                       input logic         c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b (X=%b Y=%b cin=%b)",
             tag, obs, exp, X, Y, cin_bus);
    end
  endtask

  task automatic step(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [3:0] cb, input logic [W:0] exp);
    @(negedge clk);
    X       = x;
    Y       = y;
    cin_bus = cb;
    @(posedge clk);
    #1;
    check(tag, {Cout, sum}, exp);
  endtask

  initial begin
    rst     = 1'b0;
    X       = '0;
    Y       = '0;
    cin_bus = '0;
    #1 rst = 1'b1;
    #1 check("reset", {Cout, sum}, 5'b00000);
    @(negedge clk);
    rst = 1'b0;

    step("add_a", 4'b0001, 4'b1000, 4'd1, 5'b0_1010);
    step("add_b", 4'b0010, 4'b0101, 4'd1, 5'b0_1000);
    step("add_c", 4'b0011, 4'b0100, 4'd0, 5'b0_0111);
    step("add_d", 4'b0100, 4'b0111, 4'd1, 5'b0_1100);
    step("cross_a", 4'b0111, 4'b0011, 4'd1, 5'b0_1011);
    step("cross_b", 4'b1000, 4'b0001, 4'd1, 5'b0_1010);
    step("cross_c", 4'b0110, 4'b0100, 4'd0, 5'b0_1010);
    step("ovf_a", 4'b1111, 4'b1111, 4'd1, 5'b1_1111);
    step("ovf_b", 4'b1111, 4'b0000, 4'd1, 5'b1_0000);
    step("ovf_c", 4'b1000, 4'b1000, 4'd0, 5'b1_0000);
    step("wide_cin0", 4'b0011, 4'b0100, 4'b0010, 5'b0_0111);
    step("wide_cin1", 4'b0011, 4'b0100, 4'b0101, 5'b0_1000);

    // Asynchronous reset between edges with a nonzero result held
    step("pre_rst", 4'b1111, 4'b1111, 4'd1, 5'b1_1111);
    #2 rst = 1'b1;
    #1 check("rst_async", {Cout, sum}, 5'b00000);
    X       = 4'b0011;
    Y       = 4'b0100;
    cin_bus = 4'd0;
    @(posedge clk);
    #1 check("rst_hold", {Cout, sum}, 5'b00000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 check("rst_release", {Cout, sum}, 5'b0_0111);

    // Unknown inputs for one edge, then valid data must recover
    @(negedge clk);
    X       = 'x;
    Y       = 'x;
    cin_bus = 'x;
    step("x_recover", 4'd5, 4'd6, 4'd0, 5'b0_1011);

    // Exhaustive, back-to-back: check previous result each negedge
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      if (i > 0) check("exhaustive", {Cout, sum}, prev_exp);
      v       = i[8:0];
      X       = v[8:5];
      Y       = v[4:1];
      cin_bus = {3'b000, v[0]};
      prev_exp = model(X, Y, v[0]);
      check("pkg_ref", csa_ref(X, Y, v[0]), prev_exp);
    end
    @(negedge clk);
    check("exhaustive", {Cout, sum}, prev_exp);

    // Random back-to-back traffic with random upper Cin driver bits
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (n > 0) check("random", {Cout, sum}, prev_exp);
      X        = 4'($urandom);
      Y        = 4'($urandom);
      cin_bus  = 4'($urandom);
      prev_exp = model(X, Y, cin_bus[0]);
    end
    @(negedge clk);
    check("random", {Cout, sum}, prev_exp);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
